// File: rtl/osiris_i_pkg.sv
// Shared types for the Osiris I data-memory arbiter.
// Holds the arbiter FSM state encoding and the wait-counter width helper.
// No logic lives here.
package osiris_i_pkg;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_ACK  = 1'b1
  } dmem_arb_state_t;

  // Width of a counter that must hold 0..max_wait; at least one bit so a
  // zero limit still yields a legal vector.
  function automatic int unsigned dmem_arb_cnt_w(input int unsigned max_wait);
    return (max_wait == 0) ? 1 : $clog2(max_wait + 1);
  endfunction

endpackage

// File: rtl/dmem_arb_wait_cnt.sv
// Saturating host starvation counter for the data-memory arbiter.
// Latency: count updates one cycle after clr/inc; at_max is a decode of the count.
// Backpressure: none; clear wins over increment, and the count never wraps.
module dmem_arb_wait_cnt
  import osiris_i_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic inc_i,
  output logic at_max_o
);

  localparam int unsigned CW = dmem_arb_cnt_w(MAX_WAIT);
  localparam logic [CW-1:0] LIMIT = CW'(MAX_WAIT);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign at_max_o = (cnt_q >= LIMIT);

  // Next count: clear on host grant, otherwise count denied cycles up to the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !at_max_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one synchronous data-memory port between the core MEM stage and the host port.
// Latency: core read data one cycle after the address; host ack one cycle after the grant.
// Backpressure: core is stalled for exactly the host grant cycle; host holds req until ack.
module dmem_arbiter
  import osiris_i_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned MAX_WAIT   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_core_req,
  input  logic                  i_core_we,
  input  logic [ADDR_WIDTH-1:0] i_core_addr,
  input  logic [DATA_WIDTH-1:0] i_core_wdata,
  output logic                  o_core_stall,
  output logic                  o_core_rvalid,
  output logic [DATA_WIDTH-1:0] o_core_rdata,
  input  logic                  i_host_req,
  input  logic                  i_host_we,
  input  logic [ADDR_WIDTH-1:0] i_host_addr,
  input  logic [DATA_WIDTH-1:0] i_host_wdata,
  output logic                  o_host_ack,
  output logic [DATA_WIDTH-1:0] o_host_rdata,
  output logic                  o_mem_en,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

  dmem_arb_state_t       state_q, state_d;
  logic                  ack_q;
  logic                  host_we_q;
  logic                  rvalid_q;
  logic [DATA_WIDTH-1:0] host_rdata_q;

  logic in_idle;
  logic at_max;
  logic host_grant;
  logic core_serv;

  // The host is only considered in S_IDLE; in S_ACK its still-held req is ignored.
  assign in_idle    = (state_q == S_IDLE);
  assign host_grant = in_idle && i_host_req && (!i_core_req || at_max);
  assign core_serv  = i_core_req && !host_grant;

  assign o_core_stall  = i_core_req && host_grant;
  assign o_core_rvalid = rvalid_q;
  assign o_core_rdata  = i_mem_rdata;
  assign o_host_ack    = ack_q;
  // Host read data is the memory word during the ack cycle, then the captured copy.
  assign o_host_rdata  = (ack_q && !host_we_q) ? i_mem_rdata : host_rdata_q;

  dmem_arb_wait_cnt #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (host_grant),
    .inc_i    (in_idle && i_host_req && core_serv),
    .at_max_o (at_max)
  );

  // Memory port mux: host on grant, else core, else everything parked at zero.
  always_comb begin
    o_mem_en    = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (host_grant) begin
      o_mem_en    = 1'b1;
      o_mem_we    = i_host_we;
      o_mem_addr  = i_host_addr;
      o_mem_wdata = i_host_wdata;
    end else if (core_serv) begin
      o_mem_en    = 1'b1;
      o_mem_we    = i_core_we;
      o_mem_addr  = i_core_addr;
      o_mem_wdata = i_core_wdata;
    end
  end

  // Next FSM state: a grant always completes in the following cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (host_grant) state_d = S_ACK;
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM and registered outputs; reset abandons any in-flight host access.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      ack_q        <= 1'b0;
      host_we_q    <= 1'b0;
      rvalid_q     <= 1'b0;
      host_rdata_q <= '0;
    end else begin
      state_q  <= state_d;
      rvalid_q <= core_serv && !i_core_we;
      case (state_q)
        S_IDLE: begin
          ack_q <= host_grant;
          if (host_grant) begin
            host_we_q <= i_host_we;
          end
        end
        S_ACK: begin
          ack_q <= 1'b0;
          if (!host_we_q) begin
            host_rdata_q <= i_mem_rdata;
          end
        end
        default: begin
          ack_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Single-port data-memory arbiter for Osiris I. It shares one synchronous data-memory port between the core's MEM stage and a host loader/debug port. The core has priority, and a starvation counter guarantees the host eventually wins. On a host grant the arbiter stalls the core pipeline for one cycle. It sits between the MEM-stage memory interface and the data-memory macro, so core read data arrives in time for MEM/WB capture.

## Interface
- DATA_WIDTH, 32, data word width
- ADDR_WIDTH, 8, word address width
- MAX_WAIT, 4, maximum cycles a pending host request may be denied; 0 = host always wins when pending

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- i_core_req  in  1  core MEM-stage access request
- i_core_we  in  1  core write enable
- i_core_addr  in  ADDR_WIDTH  core word address
- i_core_wdata  in  DATA_WIDTH  core write data
- o_core_stall  out  1  core access not serviced this cycle; core holds request
- o_core_rvalid  out  1  core read data valid, one cycle after a serviced core read
- o_core_rdata  out  DATA_WIDTH  core read data (memory data passthrough)
- i_host_req  in  1  host request, level, held until ack
- i_host_we  in  1  host write enable
- i_host_addr  in  ADDR_WIDTH  host word address
- i_host_wdata  in  DATA_WIDTH  host write data
- o_host_ack  out  1  one-cycle completion pulse
- o_host_rdata  out  DATA_WIDTH  host read data, registered, valid with ack, held until next ack
- o_mem_en  out  1  memory port enable
- o_mem_we  out  1  memory write enable
- o_mem_addr  out  ADDR_WIDTH  memory address
- o_mem_wdata  out  DATA_WIDTH  memory write data
- i_mem_rdata  in  DATA_WIDTH  memory read data, 1-cycle synchronous latency

## Operation
- The FSM has two states.
  - S_IDLE: the port is arbitrated in this state.
  - S_ACK: the host completes in this state.
- Host grant in S_IDLE: the host is granted when i_host_req && (!i_core_req || wait_cnt >= MAX_WAIT).
  - The host access drives the mem port.
  - The next state is S_ACK.
  - wait_cnt is cleared.
- Otherwise, in S_IDLE, if i_core_req is high, the core access drives the mem port.
  - If i_host_req is also pending, wait_cnt increments.
  - wait_cnt saturates at MAX_WAIT.
- S_ACK:
  - o_host_ack=1.
  - o_host_rdata <= i_mem_rdata on a host read; it is unchanged on a host write.
  - i_host_req is ignored this cycle.
  - The core may use the port this cycle.
  - The next state is S_IDLE.
- o_core_stall = i_core_req && host granted. It is combinational and asserts only in S_IDLE.
- o_core_rvalid is registered. It is set the cycle after a serviced core read (core_req && !core_we && !stall).
- o_core_rdata = i_mem_rdata.
- When idle, o_mem_en=0, and o_mem_we, o_mem_addr and o_mem_wdata are 0.
- wait_cnt width is $clog2(MAX_WAIT+1). It never wraps.
- At most one memory access is made per cycle. Addresses are used as-is, with no range checking.

## Timing
- Reset values:
  - state=S_IDLE, wait_cnt=0
  - o_host_ack=0, o_host_rdata=0, o_core_rvalid=0
  - o_core_stall, o_mem_* follow the idle rule (0 while rst and no requests are active)
- Core read latency: address in cycle N; data and rvalid in cycle N+1.
- Host latency: grant in cycle N, ack in cycle N+1. The minimum host request-to-request interval is 2 cycles.
- If the host still holds req in the S_IDLE cycle after ack, that is a new request.
- With simultaneous requests and wait_cnt < MAX_WAIT, the core wins.
  - With MAX_WAIT=k, a continuously pending host is granted after at most k denied cycles.
- A core stall lasts exactly one cycle per host grant. It cannot occur in back-to-back cycles.
- Reset mid-operation: a host access in flight is abandoned. No ack is issued, and the host must re-request.

## Structure
- osiris_i_pkg holds the `dmem_arb_state_t` enum (S_IDLE, S_ACK).
- Sub-module dmem_arb_wait_cnt: saturating counter with clear/inc inputs and an `at_max` output.
- The rest is the FSM plus output muxing in dmem_arbiter.

## Test plan
- Reset, then idle with no requests -> all outputs 0; state S_IDLE.
- Core read addr 0x10 (mem[0x10]=0xDEADBEEF), host idle -> o_mem_en=1, o_mem_addr=0x10; next cycle o_core_rvalid=1, o_core_rdata=0xDEADBEEF; no stall.
- Host write 0x20←0x12345678 with core idle -> mem written in cycle N; o_host_ack=1 in N+1. A following core read of 0x20 returns 0x12345678.
- Continuous core requests plus a host read, MAX_WAIT=4:
  - The core is serviced 4 cycles, with wait_cnt reaching 4.
  - Then the host is granted and o_core_stall=1 for 1 cycle.
  - Ack follows, and o_host_rdata holds the memory word.
  - The core resumes.
- Run with MAX_WAIT=0 and simultaneous requests -> host granted immediately, core stalled 1 cycle.
- Reset in the host grant cycle -> no ack the next cycle, state S_IDLE, o_host_rdata=0.
